// File: rtl/ofdm_subcarrier_scheduler_if.sv
// Stream bundle around the subcarrier scheduler: QAM symbol input and subcarrier beat output.
// master = scheduler side, slave = the surrounding source/sink.
interface ofdm_subcarrier_scheduler_if #(
   parameter int unsigned IDX_W = 6
);
   logic [5:0]       qam_symbol;
   logic             qam_symbol_valid;
   logic             qam_symbol_ready;
   logic [5:0]       sc_symbol;
   logic [1:0]       sc_type;
   logic [IDX_W-1:0] sc_index;
   logic             sc_first;
   logic             sc_last;
   logic             sc_valid;
   logic             sc_ready;

   modport master (
      input  qam_symbol, qam_symbol_valid, sc_ready,
      output qam_symbol_ready, sc_symbol, sc_type, sc_index, sc_first, sc_last, sc_valid
   );

   modport slave (
      output qam_symbol, qam_symbol_valid, sc_ready,
      input  qam_symbol_ready, sc_symbol, sc_type, sc_index, sc_first, sc_last, sc_valid
   );
endinterface

// File: rtl/ofdm_subcarrier_scheduler.sv
// Maps a QAM symbol stream onto OFDM subcarrier slots (null / pilot / data) for a burst
// of num_symbols OFDM symbols, with ready/valid flow control on input and output.
module ofdm_subcarrier_scheduler #(
   parameter int unsigned NFFT         = 64,
   parameter int unsigned NUSED_HALF   = 26,
   parameter int unsigned PILOT_STEP   = 8,
   parameter int unsigned PILOT_OFFSET = 7,
   parameter logic [5:0]  PILOT_SYM    = 6'h00,
   parameter int unsigned NSYM_W       = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NSYM_W-1:0]      num_symbols,
   output logic                   busy,
   output logic                   done,
   ofdm_subcarrier_scheduler_if.master bus
);

   localparam int unsigned KW = $clog2(NFFT);

   localparam logic [KW-1:0] L_K_LAST   = KW'(NFFT - 1);
   localparam logic [KW-1:0] L_USED_LO  = KW'(NUSED_HALF);
   localparam logic [KW-1:0] L_USED_HI  = KW'(NFFT - NUSED_HALF);
   localparam logic [KW-1:0] L_P_MASK   = KW'(PILOT_STEP - 1);
   localparam logic [KW-1:0] L_P_OFFSET = KW'(PILOT_OFFSET);

   localparam logic [1:0] L_T_NULL  = 2'b00;
   localparam logic [1:0] L_T_DATA  = 2'b01;
   localparam logic [1:0] L_T_PILOT = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            r_state;
   logic [KW-1:0]     r_k;
   logic [NSYM_W-1:0] r_sym_cnt;
   logic [NSYM_W-1:0] r_nsym;
   logic [5:0]        r_sc_symbol;
   logic [1:0]        r_sc_type;
   logic [KW-1:0]     r_sc_index;
   logic              r_sc_first;
   logic              r_sc_last;
   logic              r_sc_valid;
   logic              r_done;

   logic              w_null;
   logic              w_pilot;
   logic              w_data;
   logic              w_adv;
   logic              w_last_sym;
   logic [5:0]        w_pilot_sym;

   // Slot classification on the current subcarrier index.
   assign w_null      = (r_k == '0) || ((r_k > L_USED_LO) && (r_k < L_USED_HI));
   assign w_pilot     = !w_null && ((r_k & L_P_MASK) == L_P_OFFSET);
   assign w_data      = !w_null && !w_pilot;
   assign w_pilot_sym = r_sym_cnt[0] ? ~PILOT_SYM : PILOT_SYM;
   assign w_last_sym  = (r_sym_cnt == (r_nsym - NSYM_W'(1)));

   // Output slot may load when it is empty or being drained, and a data slot has input.
   assign w_adv = (r_state == S_RUN) && !abort
                  && (!r_sc_valid || bus.sc_ready)
                  && (!w_data || bus.qam_symbol_valid);

   assign bus.qam_symbol_ready = w_adv && w_data;
   assign bus.sc_symbol        = r_sc_symbol;
   assign bus.sc_type          = r_sc_type;
   assign bus.sc_index         = r_sc_index;
   assign bus.sc_first         = r_sc_first;
   assign bus.sc_last          = r_sc_last;
   assign bus.sc_valid         = r_sc_valid;
   assign busy                 = (r_state != S_IDLE);
   assign done                 = r_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_sym_cnt   <= '0;
         r_nsym      <= '0;
         r_sc_symbol <= '0;
         r_sc_type   <= L_T_NULL;
         r_sc_index  <= '0;
         r_sc_first  <= 1'b0;
         r_sc_last   <= 1'b0;
         r_sc_valid  <= 1'b0;
         r_done      <= 1'b0;
      end else if (abort) begin
         r_state    <= S_IDLE;
         r_k        <= '0;
         r_sym_cnt  <= '0;
         r_sc_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && (num_symbols != '0)) begin
                  r_state   <= S_RUN;
                  r_nsym    <= num_symbols;
                  r_k       <= '0;
                  r_sym_cnt <= '0;
               end
            end
            S_RUN: begin
               if (w_adv) begin
                  r_sc_valid <= 1'b1;
                  r_sc_index <= r_k;
                  r_sc_first <= (r_k == '0);
                  r_sc_last  <= (r_k == L_K_LAST);
                  if (w_null) begin
                     r_sc_type   <= L_T_NULL;
                     r_sc_symbol <= '0;
                  end else if (w_pilot) begin
                     r_sc_type   <= L_T_PILOT;
                     r_sc_symbol <= w_pilot_sym;
                  end else begin
                     r_sc_type   <= L_T_DATA;
                     r_sc_symbol <= bus.qam_symbol;
                  end
                  r_k <= r_k + KW'(1);
                  if (r_k == L_K_LAST) begin
                     r_sym_cnt <= r_sym_cnt + NSYM_W'(1);
                     if (w_last_sym) begin
                        r_state <= S_DRAIN;
                     end
                  end
               end else if (bus.sc_ready) begin
                  r_sc_valid <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (r_sc_valid && bus.sc_ready) begin
                  r_sc_valid <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_IDLE;
                  r_k        <= '0;
                  r_sym_cnt  <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ofdm_subcarrier_scheduler.sv
// Directed bench for ofdm_subcarrier_scheduler with default parameters (NFFT=64).
module tb_ofdm_subcarrier_scheduler;

   localparam int unsigned KW = 6;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic [7:0] num_symbols;
   logic       busy;
   logic       done;

   int n_assert = 0;
   int n_fail   = 0;

   ofdm_subcarrier_scheduler_if #(.IDX_W(KW)) bus ();

   ofdm_subcarrier_scheduler dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .num_symbols (num_symbols),
      .busy        (busy),
      .done        (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Expected slot type: null at DC and k=27..37, pilots at k%8==7, else data.
   function automatic logic [1:0] exp_type(input int k);
      if (k == 0 || (k >= 27 && k <= 37)) return 2'b00;
      if ((k % 8) == 7) return 2'b10;
      return 2'b01;
   endfunction

   // mode: 0 plain, 1 backpressure, 2 input underflow at k=1, 3 start while busy,
   //       4 abort at k=30 of symbol 1, 5 async reset at k=40 of symbol 1
   task automatic run_burst(input int nsym, input int mode,
                            output int beats, output int qhs, output int nfirst,
                            output int nlast, output int ndone, output int first_valid,
                            output int uf_gap);
      int         exp_k, exp_sym, exp_data;
      bit         prev_stall, ended, injected;
      logic [5:0] h_sym, e_sym;
      logic [1:0] h_type, e_type;
      logic [KW-1:0] h_idx;
      logic [15:0] pat;
      pat = 16'h9B4D;
      beats = 0; qhs = 0; nfirst = 0; nlast = 0; ndone = 0; first_valid = -1; uf_gap = 0;
      exp_k = 0; exp_sym = 0; exp_data = 0;
      prev_stall = 0; ended = 0; injected = 0;
      h_sym = '0; h_type = '0; h_idx = '0;
      @(negedge clk);
      num_symbols = 8'(nsym); start = 1'b1; abort = 1'b0;
      bus.sc_ready = 1'b1; bus.qam_symbol_valid = 1'b1; bus.qam_symbol = 6'd1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         start = 1'b0; num_symbols = 8'(nsym); abort = 1'b0;
         if (first_valid < 0 && bus.sc_valid) first_valid = cyc;
         if (prev_stall) begin
            n_assert++;
            if (bus.sc_valid !== 1'b1 || bus.sc_symbol !== h_sym || bus.sc_type !== h_type
                || bus.sc_index !== h_idx) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b k=%0d t=%0d s=%h, need v=1 k=%0d t=%0d s=%h",
                        bus.sc_valid, bus.sc_index, bus.sc_type, bus.sc_symbol, h_idx, h_type, h_sym);
            end
         end
         if (done) begin
            ndone++;
            n_assert++;
            if (beats != nsym * 64 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL done_at_end: got beats=%0d busy=%b, need beats=%0d busy=0",
                        beats, busy, nsym * 64);
            end
            ended = 1;
            break;
         end
         bus.sc_ready         = (mode == 1) ? pat[cyc % 16] : 1'b1;
         bus.qam_symbol_valid = !(mode == 2 && cyc >= 1 && cyc <= 5);
         bus.qam_symbol       = 6'(qhs + 1);
         if (mode == 3 && !injected && bus.sc_valid && bus.sc_index == KW'(19)) begin
            start = 1'b1; num_symbols = 8'd3; injected = 1;
         end
         if (mode == 4 && exp_sym == 1 && bus.sc_valid && bus.sc_index == KW'(29)) abort = 1'b1;
         if (mode == 5 && exp_sym == 1 && bus.sc_valid && bus.sc_index == KW'(39)) begin
            #1;
            reset_n = 1'b0;
            #1;
            n_assert++;
            if (bus.sc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.qam_symbol_ready !== 1'b0
                || bus.sc_symbol !== 6'd0 || bus.sc_type !== 2'd0 || bus.sc_index !== '0
                || bus.sc_first !== 1'b0 || bus.sc_last !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_mid_outputs: got v=%b busy=%b done=%b qr=%b s=%h t=%0d k=%0d f=%b l=%b, need all 0",
                        bus.sc_valid, busy, done, bus.qam_symbol_ready, bus.sc_symbol, bus.sc_type,
                        bus.sc_index, bus.sc_first, bus.sc_last);
            end
            @(negedge clk);
            reset_n = 1'b1;
            ended = 1;
            break;
         end
         #1;
         if (abort) begin
            n_assert++;
            if (bus.qam_symbol_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_no_consume: got qam_ready=%b, need 0", bus.qam_symbol_ready);
            end
            @(negedge clk);
            abort = 1'b0;
            n_assert++;
            if (bus.sc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle: got v=%b busy=%b done=%b, need 0 0 0",
                        bus.sc_valid, busy, done);
            end
            ended = 1;
            break;
         end
         if (bus.qam_symbol_ready && bus.qam_symbol_valid) qhs++;
         if (bus.sc_valid && !bus.sc_ready) begin
            n_assert++;
            if (bus.qam_symbol_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_qam_ready: got %b, need 0", bus.qam_symbol_ready);
            end
         end
         if (beats == 1 && !bus.sc_valid) uf_gap++;
         if (bus.sc_valid && bus.sc_ready) begin
            e_type = exp_type(exp_k);
            if (e_type == 2'b00)      e_sym = 6'h00;
            else if (e_type == 2'b10) e_sym = (exp_sym % 2 != 0) ? 6'h3F : 6'h00;
            else                      e_sym = 6'(exp_data + 1);
            n_assert++;
            if (bus.sc_index !== KW'(exp_k) || bus.sc_type !== e_type || bus.sc_symbol !== e_sym
                || bus.sc_first !== (exp_k == 0) || bus.sc_last !== (exp_k == 63)) begin
               n_fail++;
               $display("FAIL beat sym%0d: got k=%0d t=%0d s=%h f=%b l=%b, need k=%0d t=%0d s=%h f=%b l=%b",
                        exp_sym, bus.sc_index, bus.sc_type, bus.sc_symbol, bus.sc_first, bus.sc_last,
                        exp_k, e_type, e_sym, exp_k == 0, exp_k == 63);
            end
            if (e_type == 2'b01) exp_data++;
            if (bus.sc_first) nfirst++;
            if (bus.sc_last)  nlast++;
            beats++;
            exp_k++;
            if (exp_k == 64) begin
               exp_k = 0;
               exp_sym++;
            end
         end
         prev_stall = bus.sc_valid && !bus.sc_ready;
         h_sym = bus.sc_symbol; h_type = bus.sc_type; h_idx = bus.sc_index;
      end
      if (!ended) begin
         n_assert++;
         n_fail++;
         $display("FAIL burst_timeout: got beats=%0d, need completion", beats);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_symbols = 8'd0;
      bus.qam_symbol = 6'd5; bus.qam_symbol_valid = 1'b1; bus.sc_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_assert++;
      if (bus.sc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.qam_symbol_ready !== 1'b0
          || bus.sc_index !== '0 || bus.sc_type !== 2'd0 || bus.sc_symbol !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b busy=%b done=%b qr=%b k=%0d t=%0d s=%h, need all 0",
                  bus.sc_valid, busy, done, bus.qam_symbol_ready, bus.sc_index, bus.sc_type, bus.sc_symbol);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || bus.qam_symbol_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b qr=%b, need 0 0", busy, bus.qam_symbol_ready);
      end
   endtask

   task automatic test_basic();
      int b, q, f, l, d, fv, g;
      run_burst(1, 0, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 64 || q != 45 || f != 1 || l != 1 || d != 1) begin
         n_fail++;
         $display("FAIL basic_counts: got beats=%0d hs=%0d first=%0d last=%0d done=%0d, need 64 45 1 1 1",
                  b, q, f, l, d);
      end
      n_assert++;
      if (fv != 1) begin
         n_fail++;
         $display("FAIL basic_latency: got first valid at cycle %0d after start edge, need 1", fv);
      end
   endtask

   task automatic test_multi();
      int b, q, f, l, d, fv, g;
      run_burst(3, 0, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 192 || q != 135 || f != 3 || l != 3 || d != 1) begin
         n_fail++;
         $display("FAIL multi_counts: got beats=%0d hs=%0d first=%0d last=%0d done=%0d, need 192 135 3 3 1",
                  b, q, f, l, d);
      end
   endtask

   task automatic test_backpressure();
      int b, q, f, l, d, fv, g;
      run_burst(1, 1, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 64 || q != 45 || d != 1) begin
         n_fail++;
         $display("FAIL bp_counts: got beats=%0d hs=%0d done=%0d, need 64 45 1", b, q, d);
      end
   endtask

   task automatic test_underflow();
      int b, q, f, l, d, fv, g;
      run_burst(1, 2, b, q, f, l, d, fv, g);
      n_assert++;
      if (g != 5 || b != 64 || q != 45 || d != 1) begin
         n_fail++;
         $display("FAIL underflow: got gap=%0d beats=%0d hs=%0d done=%0d, need 5 64 45 1", g, b, q, d);
      end
   endtask

   task automatic test_control();
      int b, q, f, l, d, fv, g;
      @(negedge clk);
      start = 1'b1; num_symbols = 8'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || bus.sc_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_start: got busy=%b v=%b, need 0 0", busy, bus.sc_valid);
      end
      run_burst(1, 3, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 64 || d != 1) begin
         n_fail++;
         $display("FAIL start_ignored: got beats=%0d done=%0d, need 64 1", b, d);
      end
      run_burst(2, 4, b, q, f, l, d, fv, g);
      n_assert++;
      if (d != 0 || b != 93) begin
         n_fail++;
         $display("FAIL abort_progress: got beats=%0d done=%0d, need 93 0", b, d);
      end
      run_burst(1, 0, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 64 || q != 45 || d != 1) begin
         n_fail++;
         $display("FAIL after_abort: got beats=%0d hs=%0d done=%0d, need 64 45 1", b, q, d);
      end
   endtask

   task automatic test_reset_mid();
      int b, q, f, l, d, fv, g;
      run_burst(2, 5, b, q, f, l, d, fv, g);
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || bus.sc_valid !== 1'b0 || d != 0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: got busy=%b v=%b done=%0d, need 0 0 0", busy, bus.sc_valid, d);
      end
      run_burst(1, 0, b, q, f, l, d, fv, g);
      n_assert++;
      if (b != 64 || q != 45 || d != 1) begin
         n_fail++;
         $display("FAIL after_reset: got beats=%0d hs=%0d done=%0d, need 64 45 1", b, q, d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_backpressure();
      test_underflow();
      test_control();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
